soc_test_monitor: RTL and testbench

Parametrised, synthesizable run monitor for the riscv SoC bench. It passively snoops the core's instruction-fetch and data-memory buses and decodes stores to a memory-mapped mailbox. It captures NUM_SIG result words and a running store signature, and ends every run in a sticky PASS, FAIL, TIMEOUT or HANG status. It replaces the fixed-delay single `verify` readout and sits beside `inst_mem`/`data_mem` with no influence on bus traffic.

---
 rtl/soc_mon_pkg.sv | 18 +
 rtl/soc_mon_decode.sv | 24 ++
 rtl/soc_test_monitor.sv | 130 +++++++++++++
 tb/tb_soc_test_monitor.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/soc_mon_pkg.sv
// Shared encodings for the SoC run monitor: status codes, mailbox offsets, pass code.
// Pure definitions; no logic, no latency, no flow control.
package soc_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4,
        ST_HANG    = 3'd5
    } mon_state_t;

    localparam int TOHOST_OFS = 0;
    localparam int CHAN_OFS   = 4;
    localparam int PASS_CODE  = 1;

endpackage

// File: rtl/soc_mon_decode.sv
// Mailbox address decode: TOHOST match and one-hot result channel select.
// Purely combinational, zero latency; passive, no backpressure.
module soc_mon_decode
    import soc_mon_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                NUM_SIG   = 4,
    parameter logic [ADDR_W-1:0] MBOX_BASE = 32'h0000_1000
) (
    input  logic [ADDR_W-1:0]  addr,
    output logic               is_tohost,
    output logic [NUM_SIG-1:0] chan_sel
);

    always_comb begin
        is_tohost = (addr == MBOX_BASE + ADDR_W'(TOHOST_OFS));
        chan_sel  = '0;
        // Channel i sits one word past TOHOST plus i words.
        for (int i = 0; i < NUM_SIG; i++) begin
            chan_sel[i] = (addr == MBOX_BASE + ADDR_W'(CHAN_OFS * (i + 1)));
        end
    end

endmodule

// File: rtl/soc_test_monitor.sv
// Passive run monitor: snoops fetch/store buses, captures mailbox results, ends in a sticky verdict.
// All outputs registered, one cycle after the sampling edge; never drives or stalls the buses.
module soc_test_monitor
    import soc_mon_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_SIG     = 4,
    parameter logic [ADDR_W-1:0] MBOX_BASE   = 32'h0000_1000,
    parameter int                TIMEOUT     = 100000,
    parameter int                STALL_LIMIT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      inst_ce_i,
    input  logic [ADDR_W-1:0]         inst_addr_i,
    input  logic                      data_ce_i,
    input  logic                      data_we_i,
    input  logic [ADDR_W-1:0]         data_addr_i,
    input  logic [DATA_W-1:0]         data_i,
    output logic [2:0]                status_o,
    output logic                      done_o,
    output logic [DATA_W-1:0]         fail_code_o,
    output logic [NUM_SIG*DATA_W-1:0] result_o,
    output logic [NUM_SIG-1:0]        result_vld_o,
    output logic [DATA_W-1:0]         signature_o,
    output logic [31:0]               cycle_cnt_o
);

    localparam int STALL_W = $clog2(STALL_LIMIT) + 1;

    mon_state_t         state;
    logic [STALL_W-1:0] stall_cnt;
    logic [ADDR_W-1:0]  prev_addr;

    logic               is_tohost;
    logic [NUM_SIG-1:0] chan_sel;
    logic               store;
    logic               tohost_hit;
    logic               same_addr;
    logic [STALL_W-1:0] stall_inc;
    logic               hang_hit;
    logic [31:0]        cnt_nxt;
    logic               timeout_hit;

    function automatic logic [DATA_W-1:0] sig_step(input logic [DATA_W-1:0] s,
                                                   input logic [DATA_W-1:0] d);
        return {s[DATA_W-2:0], s[DATA_W-1]} ^ d;
    endfunction

    soc_mon_decode #(
        .ADDR_W    (ADDR_W),
        .NUM_SIG   (NUM_SIG),
        .MBOX_BASE (MBOX_BASE)
    ) u_decode (
        .addr      (data_addr_i),
        .is_tohost (is_tohost),
        .chan_sel  (chan_sel)
    );

    always_comb begin
        store       = data_ce_i && data_we_i;
        tohost_hit  = store && is_tohost && (data_i != '0);
        same_addr   = (inst_addr_i == prev_addr);
        stall_inc   = stall_cnt + 1'b1;
        hang_hit    = inst_ce_i && same_addr && (stall_inc == STALL_W'(STALL_LIMIT - 1));
        cnt_nxt     = (cycle_cnt_o == 32'hFFFF_FFFF) ? cycle_cnt_o : cycle_cnt_o + 32'd1;
        // The terminating edge itself advances the count, so TIMEOUT is seen with count TIMEOUT-1.
        timeout_hit = (cnt_nxt == 32'(TIMEOUT - 1));
    end

    assign status_o = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            done_o       <= 1'b0;
            fail_code_o  <= '0;
            result_o     <= '0;
            result_vld_o <= '0;
            signature_o  <= '0;
            cycle_cnt_o  <= '0;
            stall_cnt    <= '0;
            prev_addr    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (inst_ce_i) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    cycle_cnt_o <= cnt_nxt;
                    if (inst_ce_i) begin
                        prev_addr <= inst_addr_i;
                        stall_cnt <= same_addr ? stall_inc : '0;
                    end
                    if (store) begin
                        signature_o <= sig_step(signature_o, data_i);
                    end
                    for (int i = 0; i < NUM_SIG; i++) begin
                        if (store && chan_sel[i]) begin
                            result_o[i*DATA_W +: DATA_W] <= data_i;
                            result_vld_o[i]              <= 1'b1;
                        end
                    end
                    if (tohost_hit) begin
                        done_o <= 1'b1;
                        if (data_i == DATA_W'(PASS_CODE)) begin
                            state <= ST_PASS;
                        end else begin
                            state       <= ST_FAIL;
                            fail_code_o <= data_i;
                        end
                    end else if (hang_hit) begin
                        state  <= ST_HANG;
                        done_o <= 1'b1;
                    end else if (timeout_hit) begin
                        state  <= ST_TIMEOUT;
                        done_o <= 1'b1;
                    end
                end
                default: begin
                    // Terminal verdicts hold until reset.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_test_monitor.sv
// Directed bench for soc_test_monitor: vector table for the main run plus hand sequences for corners.
module tb_soc_test_monitor;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         inst_ce_i = 1'b0;
    logic [31:0]  inst_addr_i = '0;
    logic         data_ce_i = 1'b0;
    logic         data_we_i = 1'b0;
    logic [31:0]  data_addr_i = '0;
    logic [31:0]  data_i = '0;

    logic [2:0]   status_o, to_status;
    logic         done_o, to_done;
    logic [31:0]  fail_code_o, to_fail;
    logic [127:0] result_o, to_result;
    logic [3:0]   result_vld_o, to_vld;
    logic [31:0]  signature_o, to_sig;
    logic [31:0]  cycle_cnt_o, to_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    soc_test_monitor #(
        .TIMEOUT(1000), .STALL_LIMIT(64)
    ) dut (
        .clk(clk), .rst(rst), .inst_ce_i(inst_ce_i), .inst_addr_i(inst_addr_i),
        .data_ce_i(data_ce_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
        .data_i(data_i), .status_o(status_o), .done_o(done_o), .fail_code_o(fail_code_o),
        .result_o(result_o), .result_vld_o(result_vld_o), .signature_o(signature_o),
        .cycle_cnt_o(cycle_cnt_o)
    );

    soc_test_monitor #(
        .TIMEOUT(50), .STALL_LIMIT(64)
    ) dut_to (
        .clk(clk), .rst(rst), .inst_ce_i(inst_ce_i), .inst_addr_i(inst_addr_i),
        .data_ce_i(data_ce_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
        .data_i(data_i), .status_o(to_status), .done_o(to_done), .fail_code_o(to_fail),
        .result_o(to_result), .result_vld_o(to_vld), .signature_o(to_sig),
        .cycle_cnt_o(to_cnt)
    );

    typedef struct {
        logic         ice;
        logic [31:0]  iaddr;
        logic         dce;
        logic         dwe;
        logic [31:0]  daddr;
        logic [31:0]  ddat;
        logic [2:0]   st;
        logic         done;
        logic [31:0]  cnt;
        logic [3:0]   vld;
        logic [31:0]  sig;
        logic [127:0] res;
        logic [31:0]  fail;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step(input logic ice, input logic [31:0] ia, input logic dce,
                        input logic dwe, input logic [31:0] da, input logic [31:0] dd);
        inst_ce_i   = ice;
        inst_addr_i = ia;
        data_ce_i   = dce;
        data_we_i   = dwe;
        data_addr_i = da;
        data_i      = dd;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] ia);
        step(1'b1, ia, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic st_word(input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dd);
        step(1'b1, ia, 1'b1, 1'b1, da, dd);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
    endtask

    localparam logic [127:0] R_A5   = {96'h0, 32'hA5};
    localparam logic [127:0] R_BOTH = {32'h0, 32'h3C, 32'h0, 32'hA5};

    initial begin
        tbl[0] = '{1'b1, 32'h00, 1'b0, 1'b0, 32'h0,    32'h0,  3'd1, 1'b0, 32'd0, 4'b0000, 32'h0,   128'h0, 32'h0};
        tbl[1] = '{1'b1, 32'h04, 1'b0, 1'b0, 32'h0,    32'h0,  3'd1, 1'b0, 32'd1, 4'b0000, 32'h0,   128'h0, 32'h0};
        tbl[2] = '{1'b1, 32'h08, 1'b0, 1'b0, 32'h0,    32'h0,  3'd1, 1'b0, 32'd2, 4'b0000, 32'h0,   128'h0, 32'h0};
        tbl[3] = '{1'b1, 32'h0C, 1'b1, 1'b1, 32'h1004, 32'hA5, 3'd1, 1'b0, 32'd3, 4'b0001, 32'hA5,  R_A5,   32'h0};
        tbl[4] = '{1'b1, 32'h10, 1'b1, 1'b1, 32'h100C, 32'h3C, 3'd1, 1'b0, 32'd4, 4'b0101, 32'h176, R_BOTH, 32'h0};
        tbl[5] = '{1'b1, 32'h14, 1'b1, 1'b0, 32'h1008, 32'hFF, 3'd1, 1'b0, 32'd5, 4'b0101, 32'h176, R_BOTH, 32'h0};
        tbl[6] = '{1'b1, 32'h18, 1'b1, 1'b1, 32'h1000, 32'h0,  3'd1, 1'b0, 32'd6, 4'b0101, 32'h2EC, R_BOTH, 32'h0};
        tbl[7] = '{1'b1, 32'h1C, 1'b1, 1'b1, 32'h1000, 32'h1,  3'd2, 1'b1, 32'd7, 4'b0101, 32'h5D9, R_BOTH, 32'h0};
        tbl[8] = '{1'b1, 32'h20, 1'b1, 1'b1, 32'h1008, 32'h77, 3'd2, 1'b1, 32'd7, 4'b0101, 32'h5D9, R_BOTH, 32'h0};

        // Reset state
        do_reset();
        chk("rst_status", 128'(status_o), 128'(3'd0));
        chk("rst_done",   128'(done_o), 128'(1'b0));
        chk("rst_cnt",    128'(cycle_cnt_o), 128'(32'd0));
        chk("rst_result", result_o, 128'h0);
        chk("rst_vld",    128'(result_vld_o), 128'(4'b0));
        chk("rst_sig",    128'(signature_o), 128'(32'h0));
        chk("rst_fail",   128'(fail_code_o), 128'(32'h0));

        // Main run from the table
        for (int v = 0; v < 9; v++) begin
            step(tbl[v].ice, tbl[v].iaddr, tbl[v].dce, tbl[v].dwe, tbl[v].daddr, tbl[v].ddat);
            chk($sformatf("v%0d_status", v), 128'(status_o), 128'(tbl[v].st));
            chk($sformatf("v%0d_done", v),   128'(done_o), 128'(tbl[v].done));
            chk($sformatf("v%0d_cnt", v),    128'(cycle_cnt_o), 128'(tbl[v].cnt));
            chk($sformatf("v%0d_vld", v),    128'(result_vld_o), 128'(tbl[v].vld));
            chk($sformatf("v%0d_sig", v),    128'(signature_o), 128'(tbl[v].sig));
            chk($sformatf("v%0d_result", v), result_o, tbl[v].res);
            chk($sformatf("v%0d_fail", v),   128'(fail_code_o), 128'(tbl[v].fail));
        end

        // FAIL is sticky and keeps the first code
        do_reset();
        fetch(32'h100);
        st_word(32'h104, 32'h1000, 32'h7);
        chk("fail_status", 128'(status_o), 128'(3'd3));
        chk("fail_code",   128'(fail_code_o), 128'(32'h7));
        chk("fail_done",   128'(done_o), 128'(1'b1));
        st_word(32'h108, 32'h1000, 32'h1);
        chk("fail_sticky", 128'(status_o), 128'(3'd3));
        chk("fail_code2",  128'(fail_code_o), 128'(32'h7));
        chk("fail_sig",    128'(signature_o), 128'(32'h7));

        // Signature over non-mailbox stores; channel index past NUM_SIG is not a mailbox
        do_reset();
        fetch(32'h300);
        st_word(32'h304, 32'h2000, 32'h5);
        chk("sig_5", 128'(signature_o), 128'(32'h5));
        st_word(32'h308, 32'h2004, 32'h3);
        chk("sig_9", 128'(signature_o), 128'(32'h9));
        st_word(32'h30C, 32'h1014, 32'h0);
        chk("sig_12",     128'(signature_o), 128'(32'h12));
        chk("oob_vld",    128'(result_vld_o), 128'(4'b0));
        chk("oob_result", result_o, 128'h0);

        // HANG after 64 same-address fetches; ce=0 cycle holds the counter
        do_reset();
        fetch(32'h200);
        for (int k = 0; k < 10; k++) fetch(32'h204);
        for (int k = 0; k < 30; k++) fetch(32'h208);
        step(1'b0, 32'h999, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 33; k++) fetch(32'h208);
        chk("hang_pre_status", 128'(status_o), 128'(3'd1));
        fetch(32'h208);
        chk("hang_status", 128'(status_o), 128'(3'd5));
        chk("hang_done",   128'(done_o), 128'(1'b1));
        chk("hang_cnt",    128'(cycle_cnt_o), 128'(32'd75));
        fetch(32'h20C);
        chk("hang_sticky", 128'(status_o), 128'(3'd5));
        chk("hang_frozen", 128'(cycle_cnt_o), 128'(32'd75));

        // TIMEOUT=50 instance reaches TIMEOUT with count 49
        do_reset();
        fetch(32'h0);
        for (int k = 1; k <= 48; k++) fetch(32'(4 * k));
        chk("to_pre_status", 128'(to_status), 128'(3'd1));
        chk("to_pre_cnt",    128'(to_cnt), 128'(32'd48));
        fetch(32'h400);
        chk("to_status", 128'(to_status), 128'(3'd4));
        chk("to_cnt",    128'(to_cnt), 128'(32'd49));
        chk("to_done",   128'(to_done), 128'(1'b1));
        fetch(32'h404);
        chk("to_frozen", 128'(to_cnt), 128'(32'd49));
        chk("to_sticky", 128'(to_status), 128'(3'd4));

        // TOHOST pass wins over timeout on the same edge
        do_reset();
        fetch(32'h0);
        for (int k = 1; k <= 48; k++) fetch(32'(4 * k));
        st_word(32'h400, 32'h1000, 32'h1);
        chk("tie_status", 128'(to_status), 128'(3'd2));
        chk("tie_cnt",    128'(to_cnt), 128'(32'd49));
        chk("tie_sig",    128'(to_sig), 128'(32'h1));

        // Asynchronous reset mid-run
        do_reset();
        fetch(32'h40);
        st_word(32'h44, 32'h1004, 32'h11);
        st_word(32'h48, 32'h1010, 32'h22);
        chk("mid_vld", 128'(result_vld_o), 128'(4'b1001));
        #2 rst = 1'b0;
        #1;
        chk("arst_status", 128'(status_o), 128'(3'd0));
        chk("arst_vld",    128'(result_vld_o), 128'(4'b0));
        chk("arst_result", result_o, 128'h0);
        chk("arst_sig",    128'(signature_o), 128'(32'h0));
        chk("arst_cnt",    128'(cycle_cnt_o), 128'(32'd0));
        fetch(32'h50);
        chk("arst_held", 128'(status_o), 128'(3'd0));
        rst = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("rel_idle", 128'(status_o), 128'(3'd0));
        fetch(32'h60);
        chk("rel_run", 128'(status_o), 128'(3'd1));
        chk("rel_cnt", 128'(cycle_cnt_o), 128'(32'd0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
